// File: rtl/config_frame_writer_if.sv
// Configuration word stream: 32-bit words with a valid/ready handshake.
// The feeder drives the master side; the frame writer consumes the slave side.
interface config_frame_writer_if;
    logic [31:0] WriteData;
    logic        WriteValid;
    logic        WriteReady;

    modport master (
        output WriteData,
        output WriteValid,
        input  WriteReady
    );

    modport slave (
        input  WriteData,
        input  WriteValid,
        output WriteReady
    );
endinterface

// File: rtl/config_frame_writer.sv
// Decodes a sync/command/data word stream and drives FrameData plus a one-hot
// FrameStrobe for the tile's configuration latches, with data settled around the strobe.
module config_frame_writer #(
    parameter int          MaxFramesPerCol = 32,
    parameter int          FrameBitsPerRow = 32,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    config_frame_writer_if.slave       writePort,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       Error
);

    localparam int IdxW = $clog2(MaxFramesPerCol);
    // One extra bit so the frame count itself is representable for the range check.
    localparam logic [IdxW:0]            FrameCount   = MaxFramesPerCol[IdxW:0];
    localparam logic [MaxFramesPerCol-1:0] StrobeLsb  = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};
    localparam logic [7:0]               OpFrameWrite = 8'hA1;
    localparam logic [7:0]               OpDesync     = 8'hD0;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        STROBE,
        HOLD
    } stateType;

    stateType          state;
    stateType          stateNext;
    logic              writeReady;
    logic              transfer;
    logic [7:0]        opcode;
    logic [IdxW-1:0]   idxField;
    logic [IdxW-1:0]   frameIdx;
    logic              errorSet;
    logic              loadIdx;
    logic              loadData;
    logic              unusedWriteBits;

    assign writePort.WriteReady = writeReady;
    assign transfer             = writePort.WriteValid && writeReady;
    assign opcode               = writePort.WriteData[31:24];
    assign idxField             = writePort.WriteData[IdxW-1:0];
    assign unusedWriteBits      = &{1'b0, writePort.WriteData};

    always_comb begin
        stateNext = state;
        errorSet  = 1'b0;
        loadIdx   = 1'b0;
        loadData  = 1'b0;
        case (state)
            IDLE: begin
                if (transfer && (writePort.WriteData == SyncWord)) begin
                    stateNext = CMD;
                end
            end
            CMD: begin
                if (transfer) begin
                    case (opcode)
                        OpFrameWrite: begin
                            if ({1'b0, idxField} < FrameCount) begin
                                stateNext = DATA;
                                loadIdx   = 1'b1;
                            end else begin
                                stateNext = IDLE;
                                errorSet  = 1'b1;
                            end
                        end
                        OpDesync: stateNext = IDLE;
                        // A repeated sync word lands here as opcode 8'hFA.
                        default: begin
                            stateNext = IDLE;
                            errorSet  = 1'b1;
                        end
                    endcase
                end
            end
            DATA: begin
                if (transfer) begin
                    stateNext = STROBE;
                    loadData  = 1'b1;
                end
            end
            STROBE:  stateNext = HOLD;
            HOLD:    stateNext = CMD;
            default: stateNext = IDLE;
        endcase
    end

    // Strobe is registered from the STROBE state, so it rises one edge after
    // FrameData loads and falls one edge later, leaving a settled cycle either side.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            writeReady  <= 1'b0;
            Busy        <= 1'b0;
            Error       <= 1'b0;
            frameIdx    <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
        end else begin
            state       <= stateNext;
            writeReady  <= (stateNext == IDLE) || (stateNext == CMD) || (stateNext == DATA);
            Busy        <= (stateNext != IDLE);
            FrameStrobe <= (state == STROBE) ? (StrobeLsb << frameIdx) : '0;
            if (errorSet) begin
                Error <= 1'b1;
            end
            if (loadIdx) begin
                frameIdx <= idxField;
            end
            if (loadData) begin
                FrameData <= writePort.WriteData[FrameBitsPerRow-1:0];
            end
        end
    end

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer: a 32-frame instance and a 20-frame
// instance share clock and reset; each scenario task checks its own results.
module tb_config_frame_writer;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        CLK;
    logic        resetn;
    logic [31:0] FrameDataA;
    logic [31:0] FrameStrobeA;
    logic        BusyA;
    logic        ErrorA;
    logic [31:0] FrameDataB;
    logic [19:0] FrameStrobeB;
    logic        BusyB;
    logic        ErrorB;

    int checks = 0;
    int errors = 0;
    int strobeCntA = 0;
    int strobeCntB = 0;

    config_frame_writer_if wrA ();
    config_frame_writer_if wrB ();

    config_frame_writer dutA (
        .CLK        (CLK),
        .resetn     (resetn),
        .writePort  (wrA),
        .FrameData  (FrameDataA),
        .FrameStrobe(FrameStrobeA),
        .Busy       (BusyA),
        .Error      (ErrorA)
    );

    config_frame_writer #(.MaxFramesPerCol(20)) dutB (
        .CLK        (CLK),
        .resetn     (resetn),
        .writePort  (wrB),
        .FrameData  (FrameDataB),
        .FrameStrobe(FrameStrobeB),
        .Busy       (BusyB),
        .Error      (ErrorB)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        if (FrameStrobeA != '0) strobeCntA <= strobeCntA + 1;
        if (FrameStrobeB != '0) strobeCntB <= strobeCntB + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic sendWord(input bit toB, input logic [31:0] w);
        int   guard;
        logic rdy;
        guard = 0;
        @(negedge CLK);
        if (toB) begin
            wrB.WriteData = w; wrB.WriteValid = 1'b1;
        end else begin
            wrA.WriteData = w; wrA.WriteValid = 1'b1;
        end
        rdy = toB ? wrB.WriteReady : wrA.WriteReady;
        while (!rdy && guard < 16) begin
            @(negedge CLK);
            guard++;
            rdy = toB ? wrB.WriteReady : wrA.WriteReady;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout word %h ready got 0 want 1", w);
        end
        @(posedge CLK);
        #1;
        wrA.WriteValid = 1'b0;
        wrB.WriteValid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        wrA.WriteData = '0; wrA.WriteValid = 1'b0;
        wrB.WriteData = '0; wrB.WriteValid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (FrameDataA !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", FrameDataA); end
        checks++; if (FrameStrobeA !== 32'h0) begin errors++; $display("FAIL rst_strobe got %h want 0", FrameStrobeA); end
        checks++; if ({BusyA, ErrorA, wrA.WriteReady} !== 3'b000) begin errors++; $display("FAIL rst_ctrl busy/err/rdy got %b want 000", {BusyA, ErrorA, wrA.WriteReady}); end
        checks++; if ({BusyB, ErrorB, wrB.WriteReady} !== 3'b000) begin errors++; $display("FAIL rst_ctrlB busy/err/rdy got %b want 000", {BusyB, ErrorB, wrB.WriteReady}); end
        @(negedge CLK);
        resetn = 1'b1;
        #1;
        checks++; if (wrA.WriteReady !== 1'b0) begin errors++; $display("FAIL rst_ready_early got %b want 0", wrA.WriteReady); end
        @(posedge CLK);
        #1;
        checks++; if (wrA.WriteReady !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", wrA.WriteReady); end
        checks++; if (BusyA !== 1'b0) begin errors++; $display("FAIL rst_busy_after got %b want 0", BusyA); end
    endtask

    task automatic test_frame_write();
        int cnt0;
        cnt0 = strobeCntA;
        sendWord(1'b0, SYNC);
        sendWord(1'b0, 32'hA100_0005);
        sendWord(1'b0, 32'hDEAD_BEEF);
        checks++; if (FrameDataA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_data got %h want deadbeef", FrameDataA); end
        checks++; if (FrameStrobeA !== 32'h0) begin errors++; $display("FAIL t1_strobe_setup got %h want 0", FrameStrobeA); end
        checks++; if (wrA.WriteReady !== 1'b0) begin errors++; $display("FAIL t1_ready_strobe got %b want 0", wrA.WriteReady); end
        checks++; if (BusyA !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", BusyA); end
        @(posedge CLK); #1;
        checks++; if (FrameStrobeA !== 32'h0000_0020) begin errors++; $display("FAIL t1_strobe got %h want 00000020", FrameStrobeA); end
        checks++; if (FrameDataA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_data_strobe got %h want deadbeef", FrameDataA); end
        @(posedge CLK); #1;
        checks++; if (FrameStrobeA !== 32'h0) begin errors++; $display("FAIL t1_strobe_fall got %h want 0", FrameStrobeA); end
        checks++; if (FrameDataA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_data_hold got %h want deadbeef", FrameDataA); end
        checks++; if ({BusyA, ErrorA, wrA.WriteReady} !== 3'b101) begin errors++; $display("FAIL t1_ctrl busy/err/rdy got %b want 101", {BusyA, ErrorA, wrA.WriteReady}); end
        checks++; if (strobeCntA - cnt0 !== 1) begin errors++; $display("FAIL t1_pulses got %0d want 1", strobeCntA - cnt0); end
    endtask

    task automatic test_back_to_back();
        int cnt0;
        cnt0 = strobeCntA;
        sendWord(1'b0, 32'hA100_001F);
        sendWord(1'b0, 32'h1234_5678);
        checks++; if (FrameDataA !== 32'h1234_5678) begin errors++; $display("FAIL t2_data got %h want 12345678", FrameDataA); end
        @(posedge CLK); #1;
        checks++; if (FrameStrobeA !== 32'h8000_0000) begin errors++; $display("FAIL t2_strobe got %h want 80000000", FrameStrobeA); end
        sendWord(1'b0, 32'hD000_0000);
        checks++; if (BusyA !== 1'b0) begin errors++; $display("FAIL t2_busy_desync got %b want 0", BusyA); end
        checks++; if (FrameDataA !== 32'h1234_5678) begin errors++; $display("FAIL t2_data_keep got %h want 12345678", FrameDataA); end
        checks++; if (ErrorA !== 1'b0) begin errors++; $display("FAIL t2_error got %b want 0", ErrorA); end
        checks++; if (strobeCntA - cnt0 !== 1) begin errors++; $display("FAIL t2_pulses got %0d want 1", strobeCntA - cnt0); end
    endtask

    task automatic test_sync_filter();
        logic [31:0] words   [3] = '{32'h0000_0000, 32'h0000_0001, SYNC};
        logic        expBusy [3] = '{1'b0, 1'b0, 1'b1};
        int cnt0;
        cnt0 = strobeCntA;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            wrA.WriteData = words[i]; wrA.WriteValid = 1'b1;
            checks++; if (wrA.WriteReady !== 1'b1) begin errors++; $display("FAIL t3_ready_valid word %0d got %b want 1", i, wrA.WriteReady); end
            @(negedge CLK);
            wrA.WriteValid = 1'b0;
            checks++; if (BusyA !== expBusy[i]) begin errors++; $display("FAIL t3_busy word %0d got %b want %b", i, BusyA, expBusy[i]); end
            checks++; if (wrA.WriteReady !== 1'b1) begin errors++; $display("FAIL t3_ready_idle word %0d got %b want 1", i, wrA.WriteReady); end
        end
        checks++; if (ErrorA !== 1'b0) begin errors++; $display("FAIL t3_error got %b want 0", ErrorA); end
        checks++; if (strobeCntA - cnt0 !== 0) begin errors++; $display("FAIL t3_pulses got %0d want 0", strobeCntA - cnt0); end
        sendWord(1'b0, 32'hD000_0000);
        checks++; if (BusyA !== 1'b0) begin errors++; $display("FAIL t3_desync_busy got %b want 0", BusyA); end
    endtask

    task automatic test_index_range();
        sendWord(1'b1, SYNC);
        sendWord(1'b1, 32'hA100_0018);
        checks++; if (ErrorB !== 1'b1) begin errors++; $display("FAIL t4_error got %b want 1", ErrorB); end
        checks++; if (BusyB !== 1'b0) begin errors++; $display("FAIL t4_busy got %b want 0", BusyB); end
        checks++; if (strobeCntB !== 0) begin errors++; $display("FAIL t4_no_strobe got %0d want 0", strobeCntB); end
        sendWord(1'b1, SYNC);
        sendWord(1'b1, 32'hA100_0003);
        sendWord(1'b1, 32'hFFFF_FFFF);
        @(posedge CLK); #1;
        checks++; if (FrameStrobeB !== 20'h0_0008) begin errors++; $display("FAIL t4_strobe got %h want 00008", FrameStrobeB); end
        @(posedge CLK); #1;
        checks++; if (ErrorB !== 1'b1) begin errors++; $display("FAIL t4_error_sticky got %b want 1", ErrorB); end
        checks++; if (FrameDataB !== 32'hFFFF_FFFF) begin errors++; $display("FAIL t4_data got %h want ffffffff", FrameDataB); end
        checks++; if (strobeCntB !== 1) begin errors++; $display("FAIL t4_pulses got %0d want 1", strobeCntB); end
    endtask

    task automatic test_bad_opcode();
        int cnt0;
        cnt0 = strobeCntA;
        sendWord(1'b0, SYNC);
        sendWord(1'b0, 32'h7700_0000);
        checks++; if (ErrorA !== 1'b1) begin errors++; $display("FAIL t5_error got %b want 1", ErrorA); end
        checks++; if (BusyA !== 1'b0) begin errors++; $display("FAIL t5_busy got %b want 0", BusyA); end
        checks++; if (FrameDataA !== 32'h1234_5678) begin errors++; $display("FAIL t5_data_keep got %h want 12345678", FrameDataA); end
        @(posedge CLK); #1;
        checks++; if (strobeCntA - cnt0 !== 0) begin errors++; $display("FAIL t5_pulses got %0d want 0", strobeCntA - cnt0); end
    endtask

    task automatic test_reset_mid_write();
        sendWord(1'b0, SYNC);
        sendWord(1'b0, 32'hA100_0002);
        sendWord(1'b0, 32'hCAFE_F00D);
        @(posedge CLK); #1;
        checks++; if (FrameStrobeA !== 32'h0000_0004) begin errors++; $display("FAIL t6_strobe_pre got %h want 00000004", FrameStrobeA); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (FrameStrobeA !== 32'h0) begin errors++; $display("FAIL t6_strobe_async got %h want 0", FrameStrobeA); end
        checks++; if (FrameDataA !== 32'h0) begin errors++; $display("FAIL t6_data_async got %h want 0", FrameDataA); end
        checks++; if ({BusyA, ErrorA, wrA.WriteReady} !== 3'b000) begin errors++; $display("FAIL t6_ctrl_async busy/err/rdy got %b want 000", {BusyA, ErrorA, wrA.WriteReady}); end
        @(posedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        @(posedge CLK); #1;
        checks++; if (wrA.WriteReady !== 1'b1) begin errors++; $display("FAIL t6_ready_after got %b want 1", wrA.WriteReady); end
        sendWord(1'b0, 32'hA100_0001);
        checks++; if (BusyA !== 1'b0) begin errors++; $display("FAIL t6_ignore_busy got %b want 0", BusyA); end
        sendWord(1'b0, SYNC);
        checks++; if (BusyA !== 1'b1) begin errors++; $display("FAIL t6_rearm_busy got %b want 1", BusyA); end
        checks++; if (ErrorA !== 1'b0) begin errors++; $display("FAIL t6_error got %b want 0", ErrorA); end
    endtask

    initial begin
        test_reset();
        test_frame_write();
        test_back_to_back();
        test_sync_filter();
        test_index_range();
        test_bad_opcode();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
